// File: rtl/fifo_pkg.sv
// Shared defaults and types for the FIFO RAM controller and its read pipe.
package fifo_pkg;

    localparam int unsigned DefDataWidth  = 16;
    localparam int unsigned DefDepth      = 1024;
    localparam int unsigned DefAddrSize   = 10;
    localparam int unsigned DefRdLatency  = 2;
    localparam int unsigned DefAfMargin   = 2;
    localparam int unsigned DefCountWidth = DefAddrSize + 1;

    typedef enum logic {
        PRI_WR = 1'b0,
        PRI_RD = 1'b1
    } pri_e;

endpackage

// File: rtl/fifo_rd_pipe.sv
// Valid strobe delay line matching the RAM read latency; cleared by reset.
module fifo_rd_pipe #(
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic gnt_i,
    output logic valid_o
);

    logic [RD_LATENCY-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d = (pipe_q << 1) | RD_LATENCY'(gnt_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign valid_o = pipe_q[RD_LATENCY-1];

endmodule

// File: rtl/fifo_ram_ctrl.sv
// Synchronous FIFO controller using a single-port RAM as storage, one access per cycle.
module fifo_ram_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned DEPTH      = DefDepth,
    parameter int unsigned ADDR_SIZE  = DefAddrSize,
    parameter int unsigned RD_LATENCY = DefRdLatency,
    parameter int unsigned AF_MARGIN  = DefAfMargin
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_gnt,
    input  logic                  rd_req,
    output logic                  rd_gnt,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_parity,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_SIZE:0]    count,
    output logic                  overflow,
    output logic                  underflow,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic [ADDR_SIZE-1:0]  ram_addr,
    output logic                  ram_wr_en,
    output logic                  ram_rd_en,
    output logic                  ram_blk_select,
    output logic                  ram_dout_en,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    input  logic                  ram_parity
);

    localparam int unsigned CountWidth = ADDR_SIZE + 1;
    localparam logic [ADDR_SIZE-1:0]  LastAddr = ADDR_SIZE'(DEPTH - 1);
    localparam logic [CountWidth-1:0] FullCnt  = CountWidth'(DEPTH);
    localparam logic [CountWidth-1:0] AfCnt    = CountWidth'(DEPTH - AF_MARGIN);

    logic [ADDR_SIZE-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic                  overflow_q, underflow_q;
    pri_e                  pri_q, pri_d;
    logic                  wr_ok, rd_ok;

    assign full        = (count_q == FullCnt);
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= AfCnt);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    assign wr_ok = wr_req & ~full;
    assign rd_ok = rd_req & ~empty;

    // Priority register: flips only when both sides were eligible.
    always_ff @(posedge clk) begin
        if (rst) begin
            pri_q <= PRI_WR;
        end else begin
            pri_q <= pri_d;
        end
    end

    always_comb begin
        pri_d = pri_q;
        if (wr_ok && rd_ok) begin
            pri_d = (pri_q == PRI_WR) ? PRI_RD : PRI_WR;
        end
    end

    always_comb begin
        wr_gnt = 1'b0;
        rd_gnt = 1'b0;
        if (wr_ok && rd_ok) begin
            wr_gnt = (pri_q == PRI_WR);
            rd_gnt = (pri_q == PRI_RD);
        end else begin
            wr_gnt = wr_ok;
            rd_gnt = rd_ok;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_gnt) begin
            wr_ptr_d = (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
        end else if (rd_gnt) begin
            rd_ptr_d = (rd_ptr_q == LastAddr) ? '0 : rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= wr_req & full;
            underflow_q <= rd_req & empty;
        end
    end

    assign ram_din        = wr_data;
    assign ram_addr       = wr_gnt ? wr_ptr_q : rd_ptr_q;
    assign ram_wr_en      = wr_gnt;
    assign ram_rd_en      = rd_gnt;
    assign ram_blk_select = wr_gnt | rd_gnt;
    assign ram_dout_en    = 1'b1;

    assign rd_data   = ram_dout;
    assign rd_parity = ram_parity;

    fifo_rd_pipe #(
        .RD_LATENCY(RD_LATENCY)
    ) u_rd_pipe (
        .clk    (clk),
        .rst    (rst),
        .gnt_i  (rd_gnt),
        .valid_o(rd_valid)
    );

endmodule
